prince_affine_layer_ti: RTL
===========================

# prince_affine_layer_ti

Registered, parametrised affine layer for the threshold-implemented PRINCE S-box datapath. It applies one selectable 4-bit affine box (bypass, A1, A2 or A3) to every nibble of every share of an NSHARES-share state. An optional uniform mask refresh is applied in the same stage. It sits between the quadratic stages of the TI S-box pipeline and replaces the fixed, combinational, three-share per-box wrappers with one valid/ready pipeline stage.

## Interface
- NSHARES, 3: number of Boolean shares; legal range 2..4.
- NIBBLES, 16: nibbles per share; 16 covers the full 64-bit PRINCE state.
- REFRESH, 0: 1 enables the mask-refresh XOR using `rnd`; 0 ignores `rnd`.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  affine box select: 0 bypass, 1 A1, 2 A2, 3 A3; sampled with the input beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- x  in  NSHARES*4*NIBBLES  input shares; share s occupies bits [s*4*NIBBLES +: 4*NIBBLES]; nibble n of a share is at [n*4 +: 4].
- rnd  in  (NSHARES-1)*4*NIBBLES  fresh randomness; sampled with the input beat; unused when REFRESH=0.
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  downstream accepts the beat.
- y  out  NSHARES*4*NIBBLES  output shares, packed the same way as `x`.

## Operation
- Per nibble and share, the output is L_mode·x_s XOR (s==0 ? c_mode : 0).
  - L_mode is the 4×4 GF(2) matrix of the selected box.
  - c_mode is the box constant; it is added to share 0 only, so the unshared value maps through the full affine box.
  - Mode 0 uses L = identity, c = 0.
- Refresh (REFRESH=1):
  - Shares 0..NSHARES-2 are XORed with r_s, which is slice s of `rnd`.
  - Share NSHARES-1 is XORed with the XOR of all r_s.
  - The refresh is applied after the affine map.
  - The XOR of all output shares is unchanged by the refresh.
- Correctness invariant: XOR over s of y_s equals A_mode(XOR over s of x_s) for every nibble, for any `rnd`.
- Nibbles are processed independently. No cross-nibble mixing happens in this block.
- `mode` travels with the beat. A mode change between beats takes effect on the next accepted beat only.

## Timing
- Latency: 1 cycle. A beat accepted at edge k is visible on `y` with out_valid=1 after edge k.
- Accept condition: in_valid && in_ready. `in_ready` = !out_valid || out_ready, which allows full throughput at one beat per cycle.
- Hold: while out_valid && !out_ready, `y` and out_valid stay stable and in_ready=0. Input beats are not lost and not duplicated.
- Drain without refill: out_valid && out_ready && !in_valid → out_valid=0 after the edge.
- Simultaneous drain and accept: out_valid && out_ready && in_valid → the register loads the new beat and out_valid stays 1.
- Reset:
  - Outputs after reset: out_valid=0, y=0, and in_ready=1.
  - Reset has priority over a concurrent accept.
  - A beat held when reset asserts is discarded.
- All share registers are separate flops. No glitch-prone combinational path may combine shares before the register; only the refresh XOR across shares is permitted.

## Structure
- Package `prince_ti_pkg`:
  - 4×4 matrices L_A1, L_A2, L_A3 and constants c_A1, c_A2, c_A3, defined as 16-bit/4-bit localparams.
  - Mode encodings MODE_BYP, MODE_A1, MODE_A2, MODE_A3.
  - A `abox_apply(matrix, nibble)` function.
- Sub-module `prince_abox_share`: combinational, one nibble of one share, with inputs `mode`, `first_share` and `x[3:0]`. The layer instantiates it NSHARES×NIBBLES times in a generate loop.
- The layer owns the handshake, output register and refresh logic.

## Test plan
- Reset mid-stall:
  - Stimulus: load a beat, hold out_ready=0, assert rst for 1 cycle.
  - Required response: out_valid=0, y=0, in_ready=1 on the next cycle, and the held beat is never emitted.
- Bypass, REFRESH=0:
  - Stimulus: x share0=64'h0123456789ABCDEF, share1=64'hFFFF0000FFFF0000, share2=0.
  - Required response: y equals x one cycle later.
- Constant path:
  - Stimulus: all shares zero, mode=2.
  - Required response: share0 = c_A2 replicated in all 16 nibbles; shares 1..2 are 0.
- Invariant sweep:
  - Stimulus: each mode, every nibble value 0..F split into random shares, random `rnd`, REFRESH=1.
  - Required response: the XOR of y shares equals A_mode(value).
  - With rnd=0, y equals the REFRESH=0 result.
- Back-pressure:
  - Stimulus: 8 back-to-back beats with out_ready toggling every cycle.
  - Required response: 8 output beats in order with matching modes, none dropped or duplicated; full throughput when out_ready=1 constantly.
- Mode switch:
  - Stimulus: beat A with mode=1 immediately followed by beat B with mode=3.
  - Required response: the A output uses A1 and the B output uses A3, with no mixing.

Source files
------------

// File: rtl/prince_ti_pkg.sv
// Shared definitions for the threshold-implemented PRINCE affine boxes:
// mode encodings, linear parts (row i of a matrix at bits [4*i +: 4]) and constants.
package prince_ti_pkg;

  typedef enum logic [1:0] {
    MODE_BYP = 2'd0,
    MODE_A1  = 2'd1,
    MODE_A2  = 2'd2,
    MODE_A3  = 2'd3
  } abox_mode_e;

  // Output bit i of L*v is the parity of (row_i & v).
  localparam logic [15:0] L_BYP = 16'h8421;
  localparam logic [15:0] L_A1  = 16'h8C23;
  localparam logic [15:0] L_A2  = 16'h9425;
  localparam logic [15:0] L_A3  = 16'hF731;

  localparam logic [3:0] C_BYP = 4'h0;
  localparam logic [3:0] C_A1  = 4'h5;
  localparam logic [3:0] C_A2  = 4'hA;
  localparam logic [3:0] C_A3  = 4'h6;

  function automatic logic [3:0] abox_apply(input logic [15:0] matrix, input logic [3:0] nibble);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 0; i < 4; i++) begin
      r[i] = ^(matrix[4*i +: 4] & nibble);
    end
    return r;
  endfunction

  function automatic logic [15:0] abox_matrix(input logic [1:0] mode);
    logic [15:0] m;
    case (mode)
      MODE_A1: m = L_A1;
      MODE_A2: m = L_A2;
      MODE_A3: m = L_A3;
      default: m = L_BYP;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] abox_const(input logic [1:0] mode);
    logic [3:0] c;
    case (mode)
      MODE_A1: c = C_A1;
      MODE_A2: c = C_A2;
      MODE_A3: c = C_A3;
      default: c = C_BYP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/prince_abox_share.sv
// One nibble of one share through the selected affine box; the constant is
// only added on share 0 so the recombined value sees the full affine map.
module prince_abox_share
  import prince_ti_pkg::*;
(
  input  logic [1:0] mode,
  input  logic       first_share,
  input  logic [3:0] x,
  output logic [3:0] y
);

  assign y = abox_apply(abox_matrix(mode), x) ^ (first_share ? abox_const(mode) : 4'h0);

endmodule

// File: rtl/prince_affine_layer_ti.sv
// Registered affine layer for the shared PRINCE S-box pipeline: per-share,
// per-nibble affine box, optional uniform refresh, one valid/ready stage.
module prince_affine_layer_ti
  import prince_ti_pkg::*;
#(
  parameter int NSHARES = 3,
  parameter int NIBBLES = 16,
  parameter int REFRESH = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [1:0]                       mode,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NSHARES*4*NIBBLES-1:0]     x,
  input  logic [(NSHARES-1)*4*NIBBLES-1:0] rnd,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NSHARES*4*NIBBLES-1:0]     y
);

  localparam int SW = 4 * NIBBLES;
  localparam int W  = NSHARES * SW;

  logic [W-1:0]  aff;
  logic [SW-1:0] rsum;
  logic [W-1:0]  rmask;
  logic [W-1:0]  nxt;
  logic          accept;

  for (genvar s = 0; s < NSHARES; s++) begin : g_share
    for (genvar n = 0; n < NIBBLES; n++) begin : g_nib
      prince_abox_share u_box (
        .mode        (mode),
        .first_share ((s == 0) ? 1'b1 : 1'b0),
        .x           (x[s*SW + n*4 +: 4]),
        .y           (aff[s*SW + n*4 +: 4])
      );
    end
  end

  // Last share absorbs the XOR of all masks, so the recombined value is untouched.
  always_comb begin
    rsum = '0;
    for (int i = 0; i < NSHARES - 1; i++) begin
      rsum = rsum ^ rnd[i*SW +: SW];
    end
  end

  assign rmask = {rsum, rnd};
  assign nxt   = (REFRESH != 0) ? (aff ^ rmask) : aff;

  // Handshake: a beat transfers on any rising edge where valid && ready are both
  // high; the producer holds valid and data stable until that edge, and ready
  // never depends on valid of the same interface.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      y         <= nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
